// File: rtl/can_bit_sampler.sv
// ---------------------------------------------------------------------------
// can_bit_sampler
//
// Purpose:
//   CAN bit-timing engine. It synchronises the raw RX line and runs the
//   SYNC / SEG1 / SEG2 bit-time state machine on time-quantum strobes. It
//   samples the bus at the end of SEG1 and applies hard synchronisation and
//   soft resynchronisation on recessive-to-dominant edges.
//
// Parameters:
//   SYNC_STAGES   number of RX synchroniser flops (2 or 3)
//
// Ports:
//   clk           in   system clock, rising edge
//   rst           in   asynchronous active-high reset
//   tq_tick       in   one-cycle time-quantum strobe
//   rx            in   raw CAN RX line (1 = recessive), asynchronous
//   tseg1[3:0]    in   Prop_Seg+Phase_Seg1, length tseg1+1 TQ
//   tseg2[2:0]    in   Phase_Seg2, length tseg2+1 TQ
//   sjw[1:0]      in   sync jump width, sjw+1 TQ
//   hard_sync_en  in   next falling edge performs a hard sync
//   bit_start     out  pulse: new bit time begins
//   sample_point  out  pulse: rx_bit has just been updated
//   rx_bit        out  last sampled bit value
//   resync_done   out  pulse: a soft resync was applied
//
// Build option:
//   CAN_SAMPLE3_EN  when defined, rx_bit is the majority of the last three
//                   SEG1 samples. With only one or two samples, the last
//                   sample is used. When undefined, a single sample is taken.
// ---------------------------------------------------------------------------
module can_bit_sampler #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tq_tick,
    input  logic       rx,
    input  logic [3:0] tseg1,
    input  logic [2:0] tseg2,
    input  logic [1:0] sjw,
    input  logic       hard_sync_en,
    output logic       bit_start,
    output logic       sample_point,
    output logic       rx_bit,
    output logic       resync_done
);

    typedef enum logic [1:0] {
        ST_SYNC = 2'd0,
        ST_SEG1 = 2'd1,
        ST_SEG2 = 2'd2
    } state_t;

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_rx_prev;
    logic                   r_edge_pend;
    state_t                 r_state;
    state_t                 w_state_nxt;
    // Lengthening can stretch SEG1 past 16 TQ, so the counter carries a
    // fifth bit to reach tseg1+ext without wrapping.
    logic [4:0]             r_cnt;
    logic [4:0]             w_cnt_nxt;
    logic [4:0]             r_ext;
    logic [4:0]             w_ext_nxt;
    logic [4:0]             r_shr;
    logic [4:0]             w_shr_nxt;
    logic                   r_resynced;
    logic                   w_resynced_nxt;
    logic                   r_rx_bit;
    logic                   r_bit_start;
    logic                   r_sample_point;
    logic                   r_resync_done;

    logic                   w_rx_s;
    logic                   w_edge;
    logic                   w_edge_evt;
    logic                   w_hard;
    logic                   w_soft_ok;
    logic                   w_new_bit;
    logic                   w_sample;
    logic                   w_resync;
    logic                   w_sample_val;
    logic [4:0]             w_sj;
    logic [4:0]             w_t2;
    logic [4:0]             w_ext_cand;
    logic [4:0]             w_ext_eff;
    logic [4:0]             w_shr_eff;

    // ------------------------------------------------------------------
    // RX synchroniser and falling-edge detection
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of its source, independent of block order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync    <= '1;
            r_rx_prev <= 1'b1;
        end else begin
            r_sync    <= {r_sync[SYNC_STAGES-2:0], rx};
            r_rx_prev <= w_rx_s;
        end
    end

    assign w_rx_s     = r_sync[SYNC_STAGES-1];
    assign w_edge     = r_rx_prev & ~w_rx_s;
    // An edge on the same cycle as the tick is consumed by that tick.
    assign w_edge_evt = r_edge_pend | w_edge;

    assign w_sj       = {3'b000, sjw} + 5'd1;
    assign w_t2       = {2'b00, tseg2} + 5'd1;
    assign w_ext_cand = ((r_cnt + 5'd1) < w_sj) ? (r_cnt + 5'd1) : w_sj;
    assign w_hard     = tq_tick & w_edge_evt & hard_sync_en;
    assign w_soft_ok  = tq_tick & w_edge_evt & ~hard_sync_en & r_rx_bit & ~r_resynced;

    // ------------------------------------------------------------------
    // Bit-time state machine: next state and strobes
    // ------------------------------------------------------------------
    // NOTE: every variable written here gets a default first, so no path
    // leaves a value held and no latch is inferred.
    always_comb begin
        w_state_nxt    = r_state;
        w_cnt_nxt      = r_cnt;
        w_ext_nxt      = r_ext;
        w_shr_nxt      = r_shr;
        w_resynced_nxt = r_resynced;
        w_new_bit      = 1'b0;
        w_sample       = 1'b0;
        w_resync       = 1'b0;
        w_ext_eff      = r_ext;
        w_shr_eff      = r_shr;

        if (tq_tick) begin
            if (w_hard) begin
                w_state_nxt = ST_SEG1;
                w_cnt_nxt   = 5'd0;
                w_new_bit   = 1'b1;
            end else begin
                case (r_state)
                    ST_SYNC: begin
                        w_state_nxt = ST_SEG1;
                        w_cnt_nxt   = 5'd0;
                    end
                    ST_SEG1: begin
                        // A late edge lengthens SEG1. The new amount is
                        // already effective for this tick's end check.
                        if (w_soft_ok) begin
                            w_ext_eff      = w_ext_cand;
                            w_ext_nxt      = w_ext_cand;
                            w_resync       = 1'b1;
                            w_resynced_nxt = 1'b1;
                        end
                        if (r_cnt >= ({1'b0, tseg1} + w_ext_eff)) begin
                            w_state_nxt = ST_SEG2;
                            w_cnt_nxt   = 5'd0;
                            w_sample    = 1'b1;
                        end else begin
                            w_cnt_nxt = r_cnt + 5'd1;
                        end
                    end
                    ST_SEG2: begin
                        if (w_soft_ok && ({1'b0, w_t2} <= ({1'b0, r_cnt} + {1'b0, w_sj}))) begin
                            // The edge is close to the bit end, so the edge
                            // TQ becomes SYNC of the next bit.
                            w_state_nxt = ST_SEG1;
                            w_cnt_nxt   = 5'd0;
                            w_new_bit   = 1'b1;
                            w_resync    = 1'b1;
                        end else begin
                            if (w_soft_ok) begin
                                w_shr_eff      = w_sj;
                                w_shr_nxt      = w_sj;
                                w_resync       = 1'b1;
                                w_resynced_nxt = 1'b1;
                            end
                            // cnt >= T2-shr-1, rearranged to avoid underflow.
                            if (({1'b0, r_cnt} + {1'b0, w_shr_eff}) >= {3'b000, tseg2}) begin
                                w_state_nxt = ST_SYNC;
                                w_cnt_nxt   = 5'd0;
                                w_new_bit   = 1'b1;
                            end else begin
                                w_cnt_nxt = r_cnt + 5'd1;
                            end
                        end
                    end
                    default: begin
                        w_state_nxt = ST_SYNC;
                        w_cnt_nxt   = 5'd0;
                    end
                endcase
            end

            // A new bit time discards any adjustment from the previous one.
            if (w_new_bit) begin
                w_ext_nxt      = 5'd0;
                w_shr_nxt      = 5'd0;
                w_resynced_nxt = 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Sample value
    // ------------------------------------------------------------------
`ifdef CAN_SAMPLE3_EN
    logic [1:0] r_hist;
    logic [1:0] r_nsamp;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hist  <= 2'b11;
            r_nsamp <= 2'd0;
        end else if (tq_tick) begin
            if (w_hard || (r_state != ST_SEG1)) begin
                r_nsamp <= 2'd0;
            end else begin
                r_hist <= {r_hist[0], w_rx_s};
                if (r_nsamp != 2'd2) begin
                    r_nsamp <= r_nsamp + 2'd1;
                end
            end
        end
    end

    // Two earlier samples in this SEG1 plus the current one: majority vote.
    assign w_sample_val = (r_nsamp == 2'd2) ?
                          ((r_hist[1] & r_hist[0]) | (r_hist[1] & w_rx_s) | (r_hist[0] & w_rx_s)) :
                          w_rx_s;
`else
    assign w_sample_val = w_rx_s;
`endif

    // ------------------------------------------------------------------
    // State registers and registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state        <= ST_SYNC;
            r_cnt          <= 5'd0;
            r_ext          <= 5'd0;
            r_shr          <= 5'd0;
            r_resynced     <= 1'b0;
            r_edge_pend    <= 1'b0;
            r_rx_bit       <= 1'b1;
            r_bit_start    <= 1'b0;
            r_sample_point <= 1'b0;
            r_resync_done  <= 1'b0;
        end else begin
            r_state        <= w_state_nxt;
            r_cnt          <= w_cnt_nxt;
            r_ext          <= w_ext_nxt;
            r_shr          <= w_shr_nxt;
            r_resynced     <= w_resynced_nxt;
            r_bit_start    <= w_new_bit;
            r_sample_point <= w_sample;
            r_resync_done  <= w_resync;
            if (w_sample) begin
                r_rx_bit <= w_sample_val;
            end
            // Several edges between ticks collapse into one pending edge.
            if (tq_tick) begin
                r_edge_pend <= 1'b0;
            end else if (w_edge) begin
                r_edge_pend <= 1'b1;
            end
        end
    end

    assign bit_start    = r_bit_start;
    assign sample_point = r_sample_point;
    assign rx_bit       = r_rx_bit;
    assign resync_done  = r_resync_done;

endmodule

// File: tb/tb_can_bit_sampler.sv
// ---------------------------------------------------------------------------
// tb_can_bit_sampler
//
// Purpose:
//   Self-checking bench for can_bit_sampler with the default build. A
//   tq_tick strobe occurs every 4 clocks. Expected pulses are queued per
//   output, keyed by the edge at which they must appear. The queues are
//   popped and compared whenever the DUT pulses.
//
//   Timing used for the expectations:
//   - Tick k after a reset release sits at edge base+4k. Tick 1 enters SEG1.
//   - SEG1 holds cnt=c at the tick numbered (SEG1 entry tick)+1+c.
//   - One bit lasts 1 + T1 + T2 ticks.
//   - An rx change made just after tick k's edge is seen at tick k+1.
// ---------------------------------------------------------------------------
module tb_can_bit_sampler;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tq_tick = 1'b0;
    logic       rx = 1'b1;
    logic [3:0] tseg1 = 4'd4;
    logic [2:0] tseg2 = 3'd2;
    logic [1:0] sjw = 2'd0;
    logic       hard_sync_en = 1'b0;
    logic       bit_start;
    logic       sample_point;
    logic       rx_bit;
    logic       resync_done;

    typedef struct {
        int   e;
        logic v;
    } sp_exp_t;

    int      bs_q[$];
    sp_exp_t sp_q[$];
    int      rd_q[$];

    int vectors = 0;
    int miscompares = 0;
    int edge_n = 0;
    int tick_count = 0;
    int base = 0;
    bit armed = 1'b0;

    can_bit_sampler #(.SYNC_STAGES(2)) dut (
        .clk          (clk),
        .rst          (rst),
        .tq_tick      (tq_tick),
        .rx           (rx),
        .tseg1        (tseg1),
        .tseg2        (tseg2),
        .sjw          (sjw),
        .hard_sync_en (hard_sync_en),
        .bit_start    (bit_start),
        .sample_point (sample_point),
        .rx_bit       (rx_bit),
        .resync_done  (resync_done)
    );

    always #5 clk = ~clk;

    // Advance one clock. Sample just after the edge and check any pulses
    // against the scoreboard. Then set tq_tick for the coming edge.
    task automatic step();
        int      e;
        sp_exp_t s;
        @(posedge clk);
        #1;
        edge_n++;
        if (tq_tick && !rst) tick_count++;
        if (armed) begin
            if (bit_start === 1'b1) begin
                vectors++;
                if (bs_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL bit_start: unexpected pulse at edge %0d", edge_n);
                end else begin
                    e = bs_q.pop_front();
                    if (edge_n !== e) begin
                        miscompares++;
                        $display("FAIL bit_start: pulse at edge %0d, expected edge %0d", edge_n, e);
                    end
                end
            end
            if (sample_point === 1'b1) begin
                vectors++;
                if (sp_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL sample_point: unexpected pulse at edge %0d", edge_n);
                end else begin
                    s = sp_q.pop_front();
                    if (edge_n !== s.e || rx_bit !== s.v) begin
                        miscompares++;
                        $display("FAIL sample_point: edge %0d rx_bit %b, expected edge %0d rx_bit %b",
                                 edge_n, rx_bit, s.e, s.v);
                    end
                end
            end
            if (resync_done === 1'b1) begin
                vectors++;
                if (rd_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL resync_done: unexpected pulse at edge %0d", edge_n);
                end else begin
                    e = rd_q.pop_front();
                    if (edge_n !== e) begin
                        miscompares++;
                        $display("FAIL resync_done: pulse at edge %0d, expected edge %0d", edge_n, e);
                    end
                end
            end
        end
        tq_tick = ((edge_n + 1) % 4 == 0);
    endtask

    task automatic exp_bs(input int k);
        bs_q.push_back(base + 4 * k);
    endtask

    task automatic exp_rd(input int k);
        rd_q.push_back(base + 4 * k);
    endtask

    task automatic exp_sp(input int k, input logic v);
        sp_exp_t s;
        s.e = base + 4 * k;
        s.v = v;
        sp_q.push_back(s);
    endtask

    task automatic run_to_tick(input int k);
        int guard = 0;
        while (tick_count < k && guard < 5000) begin
            step();
            guard++;
        end
    endtask

    task automatic release_reset();
        rst        = 1'b0;
        base       = (edge_n / 4) * 4;
        tick_count = 0;
        armed      = 1'b1;
    endtask

    task automatic do_reset();
        armed = 1'b0;
        bs_q.delete();
        sp_q.delete();
        rd_q.delete();
        rst = 1'b1;
        repeat (3) step();
        release_reset();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        vectors++;
        if (bit_start !== 1'b0) begin
            miscompares++;
            $display("FAIL reset bit_start: got %b, want 0", bit_start);
        end
        vectors++;
        if (sample_point !== 1'b0) begin
            miscompares++;
            $display("FAIL reset sample_point: got %b, want 0", sample_point);
        end
        vectors++;
        if (resync_done !== 1'b0) begin
            miscompares++;
            $display("FAIL reset resync_done: got %b, want 0", resync_done);
        end
        vectors++;
        if (rx_bit !== 1'b1) begin
            miscompares++;
            $display("FAIL reset rx_bit: got %b, want 1", rx_bit);
        end
    endtask

    // T1=5, T2=3: 9 TQ (36 clk) per bit. The sample is 6 TQ (24 clk)
    // after bit_start.
    task automatic test_nominal();
        tseg1 = 4'd4; tseg2 = 3'd2; sjw = 2'd0; hard_sync_en = 1'b0; rx = 1'b1;
        do_reset();
        exp_sp(6, 1'b1);  exp_bs(9);
        exp_sp(15, 1'b1); exp_bs(18);
        exp_sp(24, 1'b1); exp_bs(27);
        run_to_tick(28);
        vectors++;
        if (bs_q.size() + sp_q.size() + rd_q.size() != 0) begin
            miscompares++;
            $display("FAIL nominal: %0d expected pulses never seen", bs_q.size() + sp_q.size() + rd_q.size());
        end
    endtask

    // Falling edge during SEG2 cnt=1 with a hard sync requested.
    task automatic test_hard_sync();
        tseg1 = 4'd4; tseg2 = 3'd2; sjw = 2'd0; hard_sync_en = 1'b1; rx = 1'b1;
        do_reset();
        exp_sp(6, 1'b1);
        exp_bs(8);
        exp_sp(13, 1'b0);
        exp_bs(16);
        run_to_tick(7);
        rx = 1'b0;
        run_to_tick(17);
        vectors++;
        if (bs_q.size() + sp_q.size() + rd_q.size() != 0) begin
            miscompares++;
            $display("FAIL hard_sync: %0d expected pulses never seen", bs_q.size() + sp_q.size() + rd_q.size());
        end
        hard_sync_en = 1'b0;
        rx = 1'b1;
    endtask

    // T1=8, SJ=2. An edge at SEG1 cnt=4 gives ext=2. A second edge in the
    // same bit is ignored. In the next bit, an edge at cnt=0 gives ext=1.
    task automatic test_lengthen();
        tseg1 = 4'd7; tseg2 = 3'd2; sjw = 2'd1; hard_sync_en = 1'b0; rx = 1'b1;
        do_reset();
        exp_rd(6);
        exp_sp(11, 1'b1);
        exp_bs(14);
        exp_rd(16);
        exp_sp(24, 1'b1);
        exp_bs(27);
        run_to_tick(5);  rx = 1'b0;
        run_to_tick(7);  rx = 1'b1;
        run_to_tick(8);  rx = 1'b0;
        run_to_tick(9);  rx = 1'b1;
        run_to_tick(15); rx = 1'b0;
        run_to_tick(16); rx = 1'b1;
        run_to_tick(28);
        vectors++;
        if (bs_q.size() + sp_q.size() + rd_q.size() != 0) begin
            miscompares++;
            $display("FAIL lengthen: %0d expected pulses never seen", bs_q.size() + sp_q.size() + rd_q.size());
        end
    endtask

    // T2=6, SJ=4. An edge at SEG2 cnt=3 restarts the bit. An edge at
    // SEG2 cnt=0 shortens SEG2 to 2 TQ. The following bit has full length.
    task automatic test_shorten();
        tseg1 = 4'd4; tseg2 = 3'd5; sjw = 2'd3; hard_sync_en = 1'b0; rx = 1'b1;
        do_reset();
        exp_sp(6, 1'b1);
        exp_rd(10);
        exp_bs(10);
        exp_sp(15, 1'b1);
        exp_rd(16);
        exp_bs(17);
        exp_sp(23, 1'b1);
        exp_bs(29);
        run_to_tick(9);  rx = 1'b0;
        run_to_tick(10); rx = 1'b1;
        run_to_tick(15); rx = 1'b0;
        run_to_tick(16); rx = 1'b1;
        run_to_tick(30);
        vectors++;
        if (bs_q.size() + sp_q.size() + rd_q.size() != 0) begin
            miscompares++;
            $display("FAIL shorten: %0d expected pulses never seen", bs_q.size() + sp_q.size() + rd_q.size());
        end
    endtask

    // Shrinking tseg1 mid-SEG1 below the current count ends SEG1 at the
    // next tick.
    task automatic test_cfg_change();
        tseg1 = 4'd15; tseg2 = 3'd2; sjw = 2'd0; hard_sync_en = 1'b0; rx = 1'b1;
        do_reset();
        exp_sp(10, 1'b1);
        exp_bs(13);
        run_to_tick(9);
        tseg1 = 4'd3;
        run_to_tick(14);
        vectors++;
        if (bs_q.size() + sp_q.size() + rd_q.size() != 0) begin
            miscompares++;
            $display("FAIL cfg_change: %0d expected pulses never seen", bs_q.size() + sp_q.size() + rd_q.size());
        end
    endtask

    // An edge in SYNC makes no adjustment. A dominant sample is followed
    // by reset mid-SEG1, then a clean restart.
    task automatic test_mid_reset();
        tseg1 = 4'd4; tseg2 = 3'd2; sjw = 2'd0; hard_sync_en = 1'b0; rx = 1'b1;
        do_reset();
        exp_sp(6, 1'b1);
        exp_bs(9);
        exp_sp(15, 1'b0);
        exp_bs(18);
        run_to_tick(9);
        rx = 1'b0;
        run_to_tick(21);
        vectors++;
        if (bs_q.size() + sp_q.size() + rd_q.size() != 0) begin
            miscompares++;
            $display("FAIL sync_edge: %0d expected pulses never seen", bs_q.size() + sp_q.size() + rd_q.size());
        end
        vectors++;
        if (rx_bit !== 1'b0) begin
            miscompares++;
            $display("FAIL pre-reset rx_bit: got %b, want 0", rx_bit);
        end
        armed = 1'b0;
        rx  = 1'b1;
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            vectors++;
            if ({bit_start, sample_point, resync_done, rx_bit} !== 4'b0001) begin
                miscompares++;
                $display("FAIL mid_reset cycle %0d: bs/sp/rd/rx_bit got %b%b%b%b, want 0001",
                         i, bit_start, sample_point, resync_done, rx_bit);
            end
        end
        release_reset();
        exp_sp(6, 1'b1);
        exp_bs(9);
        run_to_tick(10);
        vectors++;
        if (bs_q.size() + sp_q.size() + rd_q.size() != 0) begin
            miscompares++;
            $display("FAIL post_reset: %0d expected pulses never seen", bs_q.size() + sp_q.size() + rd_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_hard_sync();
        test_lengthen();
        test_shorten();
        test_cfg_change();
        test_mid_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
